// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the five-stage pipeline controller:
//   - REG_W          register-number width (4 -> R0..R15)
//   - STALL_CNT_W    width of the stall-cycle counter output
//   - ctrl_state_e   2-bit controller FSM state encoding
//   - ctrl_out_t     bundle of the pipeline-register write/flush controls
//   - ctrl_all()     helper building a control bundle with every write equal
//                    to the argument and every flush cleared
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int REG_W       = 4;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    DRAIN     = 2'd2,
    HALT      = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_write;
  } ctrl_out_t;

  function automatic ctrl_out_t ctrl_all(input logic wr);
    ctrl_out_t c;
    c.pc_write     = wr;
    c.if_id_write  = wr;
    c.if_id_flush  = 1'b0;
    c.id_ex_write  = wr;
    c.id_ex_flush  = 1'b0;
    c.ex_mem_write = wr;
    c.mem_wb_write = wr;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard comparator. Flags when the instruction
// in EX is a load whose destination is read by the instruction in ID. R0 is
// hard-wired to zero, so a load targeting R0 never creates a dependency.
// Ports:
//   id_src1, id_src2  in  REG_W  ID-stage source register numbers
//   id_use1, id_use2  in  1      the matching source is actually read
//   ex_dst_reg        in  REG_W  EX-stage destination register
//   ex_mem_read       in  1      EX instruction is a load
//   load_use          out 1      hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] ex_dst_reg,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit = id_use1 && (id_src1 == ex_dst_reg);
  assign src2_hit = id_use2 && (id_src2 == ex_dst_reg);
  assign load_use = ex_mem_read && (ex_dst_reg != '0) && (src1_hit || src2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Stall / flush / halt controller for a five-stage pipeline. A small FSM
// (RUN, DMEM_WAIT, DRAIN, HALT) plus combinational output logic decides, every
// cycle, which pipeline registers capture and which get a NOP.
// Event priority, highest first: HALT state, dmem_busy, load-use, taken
// branch in ID, HLT in ID, imem_busy, normal advance.
// Optional feature: define PIPE_STALL_CNT_EN to build a saturating counter of
// cycles with pc_write=0 outside HALT; otherwise stall_cycles is tied to 0.
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   id_src1/2, id_use1/2          ID-stage source operands
//   ex_dstReg, ex_mem_read        EX-stage destination and load flag
//   id_br_taken, id_hlt, wb_hlt   branch taken / HLT in ID / HLT in WB
//   imem_busy, dmem_busy          memory not ready this cycle
//   pc_write .. mem_wb_write      pipeline register write / flush controls
//   halted                        processor stopped until reset
//   stall_cycles                  stall-cycle count (0 unless counter built)
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_W-1:0]       id_src1,
  input  logic [REG_W-1:0]       id_src2,
  input  logic                   id_use1,
  input  logic                   id_use2,
  input  logic [REG_W-1:0]       ex_dstReg,
  input  logic                   ex_mem_read,
  input  logic                   id_br_taken,
  input  logic                   id_hlt,
  input  logic                   wb_hlt,
  input  logic                   imem_busy,
  input  logic                   dmem_busy,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_write,
  output logic                   id_ex_flush,
  output logic                   ex_mem_write,
  output logic                   mem_wb_write,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  ctrl_state_e state, state_nxt;
  ctrl_state_e eff_state;
  logic        ret_drain, ret_drain_nxt;
  logic        bubble_done, bubble_done_nxt;
  logic        load_use;
  ctrl_out_t   ctl;
  logic        halted_c;

  hazard_detect u_hazard_detect (
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .ex_dst_reg  (ex_dstReg),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // State register. ret_drain remembers whether a data-memory wait interrupted
  // a drain, so the drain resumes afterwards. bubble_done marks that the
  // previous advancing cycle already inserted the load-use bubble, which
  // keeps a still-visible hazard from stalling a second time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      ret_drain   <= 1'b0;
      bubble_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      ret_drain   <= ret_drain_nxt;
      bubble_done <= bubble_done_nxt;
    end
  end

  // Next-state and output decode. Once the data memory releases, DMEM_WAIT
  // behaves exactly like the state it interrupted (eff_state), so the release
  // cycle is already a productive cycle rather than an extra stall. Reset low
  // forces every control to zero immediately, independent of the flops.
  always_comb begin
    ctl             = ctrl_all(1'b1);
    halted_c        = 1'b0;
    state_nxt       = state;
    ret_drain_nxt   = ret_drain;
    bubble_done_nxt = bubble_done;
    eff_state       = state;
    if (state == DMEM_WAIT) begin
      eff_state = ret_drain ? DRAIN : RUN;
    end

    if (state == HALT) begin
      ctl      = ctrl_all(1'b0);
      halted_c = 1'b1;
    end else if (dmem_busy) begin
      ctl       = ctrl_all(1'b0);
      state_nxt = DMEM_WAIT;
      if (state != DMEM_WAIT) begin
        ret_drain_nxt = (state == DRAIN);
      end
    end else if (eff_state == DRAIN) begin
      // Fetch is frozen and IF/ID fed NOPs; EX, MEM and WB keep retiring
      // until the HLT reaches write-back.
      ctl.pc_write    = 1'b0;
      ctl.if_id_flush = 1'b1;
      bubble_done_nxt = 1'b0;
      state_nxt       = wb_hlt ? HALT : DRAIN;
    end else begin
      state_nxt       = RUN;
      bubble_done_nxt = 1'b0;
      if (load_use && !bubble_done) begin
        ctl.pc_write    = 1'b0;
        ctl.if_id_write = 1'b0;
        ctl.id_ex_flush = 1'b1;
        bubble_done_nxt = 1'b1;
      end else if (id_br_taken) begin
        ctl.if_id_flush = 1'b1;
      end else if (id_hlt) begin
        ctl.pc_write    = 1'b0;
        ctl.if_id_flush = 1'b1;
        state_nxt       = DRAIN;
      end else if (imem_busy) begin
        ctl.pc_write    = 1'b0;
        ctl.if_id_flush = 1'b1;
      end
    end

    if (!rst) begin
      ctl      = ctrl_all(1'b0);
      halted_c = 1'b0;
    end
  end

  assign pc_write     = ctl.pc_write;
  assign if_id_write  = ctl.if_id_write;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_write  = ctl.id_ex_write;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_write = ctl.ex_mem_write;
  assign mem_wb_write = ctl.mem_wb_write;
  assign halted       = halted_c;

`ifdef PIPE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt;

  // Saturating count of cycles in which fetch did not advance, excluding the
  // permanent stop in HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!ctl.pc_write && (state != HALT) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Scoreboard bench for pipeline_ctrl. The stimulus process drives one input
// vector per cycle, evaluates a behavioural model of the controller rules and
// pushes the expected outputs; a monitor process pops and compares on the
// falling edge. Directed scenarios are followed by randomized bursts.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_src1, id_src2, ex_dstReg;
  logic        id_use1, id_use2, ex_mem_read;
  logic        id_br_taken, id_hlt, wb_hlt, imem_busy, dmem_busy;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic        ex_mem_write, mem_wb_write, halted;
  logic [15:0] stall_cycles;

  typedef struct {
    bit         rst_n;
    logic [3:0] src1, src2, dst;
    bit         use1, use2, mem_read, br, hlt, whlt, imem, dmem;
  } stim_t;

  typedef struct {
    bit pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, hlt;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state: the controller is either stopped, draining
  // towards a HLT, or running; a data-memory wait simply freezes all of it.
  bit m_halted, m_draining, m_bubble;
  int m_stalls;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_use1      (id_use1),
    .id_use2      (id_use2),
    .ex_dstReg    (ex_dstReg),
    .ex_mem_read  (ex_mem_read),
    .id_br_taken  (id_br_taken),
    .id_hlt       (id_hlt),
    .wb_hlt       (wb_hlt),
    .imem_busy    (imem_busy),
    .dmem_busy    (dmem_busy),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_write  (id_ex_write),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_write (ex_mem_write),
    .mem_wb_write (mem_wb_write),
    .halted       (halted),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s.rst_n = 1'b1; s.src1 = 4'd0; s.src2 = 4'd0; s.dst = 4'd0;
    s.use1 = 1'b0; s.use2 = 1'b0; s.mem_read = 1'b0; s.br = 1'b0;
    s.hlt = 1'b0; s.whlt = 1'b0; s.imem = 1'b0; s.dmem = 1'b0;
    return s;
  endfunction

  // Drive one cycle of inputs shortly after the rising edge, predict the
  // outputs for this cycle and advance the model to the next cycle.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   hz, bubble_now;
    @(posedge clk);
    #1;
    rst = s.rst_n; id_src1 = s.src1; id_src2 = s.src2; ex_dstReg = s.dst;
    id_use1 = s.use1; id_use2 = s.use2; ex_mem_read = s.mem_read;
    id_br_taken = s.br; id_hlt = s.hlt; wb_hlt = s.whlt;
    imem_busy = s.imem; dmem_busy = s.dmem;

    e.pc_w = 0; e.ifid_w = 0; e.ifid_f = 0; e.idex_w = 0; e.idex_f = 0;
    e.exmem_w = 0; e.memwb_w = 0; e.hlt = 0; e.cnt = 0;
    if (!s.rst_n) begin
      m_halted = 0; m_draining = 0; m_bubble = 0; m_stalls = 0;
      exp_q.push_back(e);
      return;
    end
`ifdef PIPE_STALL_CNT_EN
    e.cnt = m_stalls;
`endif
    hz = s.mem_read && (s.dst != 0) &&
         ((s.use1 && s.src1 == s.dst) || (s.use2 && s.src2 == s.dst));
    bubble_now = 0;
    if (m_halted) begin
      e.hlt = 1;
    end else if (!s.dmem) begin
      e.pc_w = 1; e.ifid_w = 1; e.idex_w = 1; e.exmem_w = 1; e.memwb_w = 1;
      if (m_draining) begin
        e.pc_w = 0; e.ifid_f = 1;
        if (s.whlt) m_halted = 1;
      end else if (hz && !m_bubble) begin
        e.pc_w = 0; e.ifid_w = 0; e.idex_f = 1; bubble_now = 1;
      end else if (s.br) begin
        e.ifid_f = 1;
      end else if (s.hlt) begin
        e.pc_w = 0; e.ifid_f = 1; m_draining = 1;
      end else if (s.imem) begin
        e.pc_w = 0; e.ifid_f = 1;
      end
    end
    if (!e.hlt && !e.pc_w && m_stalls < 65535) m_stalls++;
    if (!(s.dmem && !e.hlt)) m_bubble = bubble_now;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every queued prediction against the DUT mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc_write",     int'(pc_write),     int'(e.pc_w));
        checkOutput("if_id_write",  int'(if_id_write),  int'(e.ifid_w));
        checkOutput("if_id_flush",  int'(if_id_flush),  int'(e.ifid_f));
        checkOutput("id_ex_write",  int'(id_ex_write),  int'(e.idex_w));
        checkOutput("id_ex_flush",  int'(id_ex_flush),  int'(e.idex_f));
        checkOutput("ex_mem_write", int'(ex_mem_write), int'(e.exmem_w));
        checkOutput("mem_wb_write", int'(mem_wb_write), int'(e.memwb_w));
        checkOutput("halted",       int'(halted),       int'(e.hlt));
        checkOutput("stall_cycles", int'(stall_cycles), e.cnt);
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized bursts.
  initial begin : stimulus
    stim_t s;
    int    guard;
    rst = 1'b1; id_src1 = 0; id_src2 = 0; ex_dstReg = 0; id_use1 = 0; id_use2 = 0;
    ex_mem_read = 0; id_br_taken = 0; id_hlt = 0; wb_hlt = 0; imem_busy = 0; dmem_busy = 0;
    m_halted = 0; m_draining = 0; m_bubble = 0; m_stalls = 0;

    s = quiet(); s.rst_n = 0;
    repeat (2) applyStimulus(s);
    repeat (2) applyStimulus(quiet());

    // Load-use on src1: one bubble, then normal with the same operands.
    s = quiet(); s.mem_read = 1; s.dst = 4'd3; s.src1 = 4'd3; s.use1 = 1;
    repeat (2) applyStimulus(s);
    applyStimulus(quiet());
    // R0 destination never stalls.
    s = quiet(); s.mem_read = 1; s.dst = 4'd0; s.src1 = 4'd0; s.use1 = 1;
    applyStimulus(s);
    // Load-use through src2, and an unused matching src1.
    s = quiet(); s.mem_read = 1; s.dst = 4'd9; s.src2 = 4'd9; s.use2 = 1;
    applyStimulus(s);
    applyStimulus(quiet());
    s = quiet(); s.mem_read = 1; s.dst = 4'd5; s.src1 = 4'd5; s.use1 = 0;
    applyStimulus(s);

    // Data memory busy for four cycles, then back to RUN.
    s = quiet(); s.dmem = 1;
    repeat (4) applyStimulus(s);
    applyStimulus(quiet());

    // Taken branch wins over instruction-memory busy; imem_busy alone stalls.
    s = quiet(); s.br = 1; s.imem = 1;
    applyStimulus(s);
    s = quiet(); s.imem = 1;
    repeat (2) applyStimulus(s);
    applyStimulus(quiet());

    // Reset during a data-memory wait, then normal RUN after release.
    s = quiet(); s.dmem = 1;
    repeat (2) applyStimulus(s);
    s.rst_n = 0;
    applyStimulus(s);
    repeat (2) applyStimulus(quiet());

    // HLT in ID, three drain cycles, then halted while inputs toggle.
    s = quiet(); s.hlt = 1;
    applyStimulus(s);
    repeat (2) applyStimulus(quiet());
    s = quiet(); s.whlt = 1;
    applyStimulus(s);
    for (int i = 0; i < 6; i++) begin
      s = quiet(); s.br = i[0]; s.dmem = i[1]; s.hlt = 1; s.imem = 1;
      applyStimulus(s);
    end

    // Drain interrupted by a data-memory wait resumes draining afterwards.
    s = quiet(); s.rst_n = 0;
    applyStimulus(s);
    s = quiet(); s.hlt = 1;
    applyStimulus(s);
    applyStimulus(quiet());
    s = quiet(); s.dmem = 1;
    repeat (2) applyStimulus(s);
    applyStimulus(quiet());
    s = quiet(); s.whlt = 1;
    applyStimulus(s);
    repeat (2) applyStimulus(quiet());

    // Randomized bursts, each starting from reset.
    for (int b = 0; b < 6; b++) begin
      s = quiet(); s.rst_n = 0;
      applyStimulus(s);
      for (int c = 0; c < 200; c++) begin
        s = quiet();
        s.src1 = 4'($urandom_range(0, 3));
        s.src2 = 4'($urandom_range(0, 3));
        s.dst  = 4'($urandom_range(0, 3));
        s.use1 = ($urandom_range(0, 99) < 60);
        s.use2 = ($urandom_range(0, 99) < 60);
        s.mem_read = ($urandom_range(0, 99) < 50);
        s.br   = ($urandom_range(0, 99) < 20);
        s.hlt  = ($urandom_range(0, 99) < 3);
        s.whlt = ($urandom_range(0, 99) < 30);
        s.imem = ($urandom_range(0, 99) < 20);
        s.dmem = ($urandom_range(0, 99) < 15);
        applyStimulus(s);
      end
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("scoreboard_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
